// File: rtl/uart_tx_fifo_bus_pkg.sv
// Shared types and constants for the bus-attached UART transmitter.
// Offsets, FSM state encoding, status word layout and bus bundles.
package uart_pkg;

  localparam logic [4:0] UART_DATA_OFS = 5'd28;
  localparam logic [4:0] UART_DIV_OFS  = 5'd24;
  localparam int         UART_MIN_DIV  = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_tx_state_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        busy;
    logic        full;
    logic        empty;
  } uart_tx_status_t;

  typedef struct packed {
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

endpackage

// File: rtl/uart_tx_fifo_bus_if.sv
// XT high-speed bus slave port: address/data bundle, strobes and read data.
interface uart_tx_fifo_bus_if;
  import uart_pkg::*;

  hb_slave_t   xt_hb;
  sel_t        sel;
  logic [31:0] rdata;

  modport slave  (input xt_hb, input sel, output rdata);
  modport master (output xt_hb, output sel, input rdata);
endinterface

// File: rtl/uart_tx_fifo_bus_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push against the registered full flag is dropped even if a pop frees a slot.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
endmodule

// File: rtl/uart_tx_fifo_bus.sv
// 8N1 UART transmitter behind a TX FIFO on the XT bus; interrupt pulses when the
// FIFO has drained and the last stop bit has finished.
module uart_tx_fifo_bus
  import uart_pkg::*;
#(
  parameter int              FIFO_DEPTH  = 8,
  parameter int              DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868
) (
  input  logic               hb_clk_i,
  input  logic               rst_i,
  uart_tx_fifo_bus_if.slave  bus,
  output logic               tx_irq_o,
  output logic               uart_tx_o
);
  localparam logic [1:0] IDLE  = UART_IDLE;
  localparam logic [1:0] START = UART_START;
  localparam logic [1:0] DATA  = UART_DATA;
  localparam logic [1:0] STOP  = UART_STOP;
  localparam int         CW    = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       waddr, raddr;
  logic [DIV_W-1:0] wdiv;
  logic             wr_data, wr_div, rd_status;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             unused_bus;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d, fdiv_q, fdiv_d, div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d, baud_end;
  logic [31:0]      rdata_q, rdata_d;
  uart_tx_status_t  status;

  assign waddr      = bus.xt_hb.waddr[4:0];
  assign raddr      = bus.xt_hb.raddr[4:0];
  assign wdiv       = bus.xt_hb.wdata[DIV_W-1:0];
  assign unused_bus = ^{bus.xt_hb.waddr[31:5], bus.xt_hb.raddr[31:5], bus.xt_hb.wdata[31:DIV_W]};

  assign wr_data   = bus.sel.wen && (waddr == UART_DATA_OFS);
  assign wr_div    = bus.sel.wen && (waddr == UART_DIV_OFS) && (wdiv >= DIV_W'(UART_MIN_DIV));
  assign rd_status = bus.sel.ren && (raddr != UART_DATA_OFS) && (raddr != UART_DIV_OFS);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (hb_clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_data),
    .wdata_i (bus.xt_hb.wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status          = '0;
    status.empty    = fifo_empty;
    status.full     = fifo_full;
    status.busy     = (state_q != IDLE);
    status.overflow = ovf_q;
    status.count    = 4'(fifo_count);
  end

  always_comb begin
    div_d = wr_div ? wdiv : div_q;
    ovf_d = ovf_q;
    if (wr_data && fifo_full) ovf_d = 1'b1;
    else if (rd_status)       ovf_d = 1'b0;
    if (raddr == UART_DATA_OFS)     rdata_d = '0;
    else if (raddr == UART_DIV_OFS) rdata_d = 32'(div_q);
    else                            rdata_d = status;
  end

  assign baud_end = (baud_q == fdiv_q - DIV_W'(1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + DIV_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fdiv_d   = fdiv_q;
    tx_d     = tx_q;
    irq_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          fdiv_d   = div_q;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[1];
        end
      end
      default: if (baud_end) begin
        // Chain straight into the next start bit so queued frames stay contiguous.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          fdiv_d   = div_q;
          state_d  = START;
          tx_d     = 1'b0;
        end else begin
          state_d = IDLE;
          irq_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge hb_clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fdiv_q  <= DEFAULT_DIV;
      div_q   <= DEFAULT_DIV;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fdiv_q  <= fdiv_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      if (bus.sel.ren) rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign uart_tx_o = tx_q;
  assign tx_irq_o  = irq_q;
endmodule

// File: tb/tb_uart_tx_fifo_bus.sv
// Scoreboard bench: bus stimulus pushes expected bytes; a serial monitor decodes frames.
module tb_uart_tx_fifo_bus;
  import uart_pkg::*;

  localparam int DEPTH = 8;

  logic hb_clk = 1'b0;
  logic rst    = 1'b1;
  logic tx_irq, uart_tx;
  always #5 hb_clk = ~hb_clk;

  uart_tx_fifo_bus_if bus();

  uart_tx_fifo_bus #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DEFAULT_DIV(16'd868)) dut (
    .hb_clk_i  (hb_clk),
    .rst_i     (rst),
    .bus       (bus),
    .tx_irq_o  (tx_irq),
    .uart_tx_o (uart_tx)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge hb_clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] exp_q[$];
  int start_q[$];
  int acc_cnt = 0, started = 0, ovf_m = 0;
  int div_m = 868, div_prev_m = 868, div_cyc_m = -1;
  int last_start = -1, irq_cyc = -1, irq_cnt = 0, last_wr_cyc = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
    end
  endtask

  // Serial monitor: decodes each frame cycle by cycle against the next expected byte.
  initial begin
    int s, fdiv, bad, k;
    bit aborted;
    logic [7:0] b;
    logic eb;
    forever begin
      @(negedge hb_clk);
      if (!rst && uart_tx === 1'b0) begin
        s = cyc; bad = 0; aborted = 0;
        started++;
        last_start = s;
        start_q.push_back(s);
        fdiv = (div_cyc_m < s) ? div_m : div_prev_m;
        if (exp_q.size() == 0) begin
          b = 8'h00;
          check("unexpected_frame", 1, 0);
        end else b = exp_q.pop_front();
        for (int i = 0; i < 10 * fdiv; i++) begin
          if (i > 0) @(negedge hb_clk);
          if (rst) begin aborted = 1; break; end
          k = i / fdiv;
          eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
          if (uart_tx !== eb) bad++;
        end
        if (!aborted) check($sformatf("frame_0x%02h_bad_cycles", b), bad, 0);
      end
    end
  end

  initial begin
    logic irq_prev;
    irq_prev = 1'b0;
    forever begin
      @(negedge hb_clk);
      if (tx_irq === 1'b1) begin
        irq_cnt++;
        irq_cyc = cyc;
        check("irq_pulse_width", int'(irq_prev), 0);
      end
      irq_prev = tx_irq;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hb_clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] ofs, input int d);
    bus.xt_hb.waddr = 32'(ofs);
    bus.xt_hb.wdata = d;
    bus.sel.wen = 1'b1;
    @(posedge hb_clk); #1;
    bus.sel.wen = 1'b0;
    last_wr_cyc = cyc;
    if (ofs == UART_DATA_OFS) begin
      if (acc_cnt - started < DEPTH) begin
        acc_cnt++;
        exp_q.push_back(d[7:0]);
      end else ovf_m = 1;
    end else if (ofs == UART_DIV_OFS && (d & 32'hFFFF) >= 4) begin
      div_prev_m = div_m;
      div_m = d & 32'hFFFF;
      div_cyc_m = cyc;
    end
  endtask

  task automatic rd(input logic [4:0] ofs, output int act, output int expv);
    int cnt, st;
    bus.xt_hb.raddr = 32'(ofs);
    bus.sel.ren = 1'b1;
    @(posedge hb_clk); #1;
    bus.sel.ren = 1'b0;
    act = int'(bus.rdata);
    cnt = acc_cnt - started;
    st = ((cnt == 0) ? 1 : 0) + ((cnt == DEPTH) ? 2 : 0) + ((last_start > irq_cyc) ? 4 : 0)
       + (ovf_m * 8) + (cnt * 256);
    if (ofs == UART_DATA_OFS) expv = 0;
    else if (ofs == UART_DIV_OFS) expv = div_m;
    else begin
      expv = st;
      ovf_m = 0;
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] ofs);
    int a, e;
    rd(ofs, a, e);
    check(name, a, e);
  endtask

  task automatic wait_irq(input int tgt, input int budget, input string name);
    int i = 0;
    while (irq_cnt < tgt && i < budget) begin @(negedge hb_clk); i++; end
    check(name, irq_cnt, tgt);
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_cnt = 0; started = 0; ovf_m = 0;
    div_m = 868; div_prev_m = 868; div_cyc_m = -1;
    last_start = -1; irq_cyc = -1;
  endtask

  initial begin
    int a, e, n0, tgt, nb, d, ic, ns;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, e, n0, tgt, nb, d, ic, ns;
    bus.xt_hb = '0;
    bus.sel   = '0;
    rst = 1'b1;
    tick(3);
    model_reset();
    rst = 1'b0;
    @(negedge hb_clk);
    check("reset_uart_tx", int'(uart_tx), 1);
    check("reset_tx_irq", int'(tx_irq), 0);
    check("reset_rdata", int'(bus.rdata), 0);
    rd_chk("reset_status", 5'd0);
    rd_chk("reset_div", UART_DIV_OFS);

    // Single 0x55 frame at div 4
    wr(UART_DIV_OFS, 4);
    wr(UART_DATA_OFS, 32'h55);
    wait_irq(1, 200, "t1_irq_count");
    check("t1_push_to_start", last_start - last_wr_cyc, 1);
    check("t1_frame_len", irq_cyc - last_start, 40);

    // Three contiguous frames at div 8
    wr(UART_DIV_OFS, 8);
    n0 = start_q.size();
    wr(UART_DATA_OFS, 32'hA3);
    wr(UART_DATA_OFS, 32'h0F);
    wr(UART_DATA_OFS, 32'hFF);
    wait_irq(2, 400, "t2_irq_after_burst");
    tick(30);
    check("t2_single_irq", irq_cnt, 2);
    check("t2_frames", start_q.size() - n0, 3);
    if (start_q.size() >= n0 + 3) begin
      check("t2_gap01", start_q[n0+1] - start_q[n0], 80);
      check("t2_gap12", start_q[n0+2] - start_q[n0+1], 80);
      check("t2_burst_len", irq_cyc - start_q[n0], 240);
    end

    // Overflow: 9 pushes while a frame is in flight
    wr(UART_DIV_OFS, 4);
    wr(UART_DATA_OFS, $urandom_range(0, 255));
    tick(3);
    for (int i = 0; i < 9; i++) wr(UART_DATA_OFS, $urandom_range(0, 255));
    rd(5'd0, a, e);
    check("t3_status_full", a, e);
    check("t3_status_const", a & 32'hF0B, 32'h80A);
    rd(5'd0, a, e);
    check("t3_status_ovf_clear", a, e);
    check("t3_ovf_bit", (a >> 3) & 1, 0);
    tgt = irq_cnt + 1;
    wait_irq(tgt, 600, "t3_drain_irq");

    // Mid-frame divisor change, and an ignored too-small divisor
    wr(UART_DIV_OFS, 4);
    n0 = start_q.size();
    wr(UART_DATA_OFS, $urandom_range(0, 255));
    wr(UART_DATA_OFS, $urandom_range(0, 255));
    tick(10);
    wr(UART_DIV_OFS, 12);
    wr(UART_DIV_OFS, 2);
    rd_chk("t4_div_readback", UART_DIV_OFS);
    tgt = irq_cnt + 1;
    wait_irq(tgt, 400, "t4_irq");
    check("t4_frames", start_q.size() - n0, 2);
    if (start_q.size() >= n0 + 2) begin
      check("t4_first_len", start_q[n0+1] - start_q[n0], 40);
      check("t4_second_len", irq_cyc - start_q[n0+1], 120);
    end

    // Reset during DATA of the second queued byte
    wr(UART_DIV_OFS, 4);
    n0 = start_q.size();
    for (int i = 0; i < 3; i++) wr(UART_DATA_OFS, $urandom_range(0, 255));
    for (int i = 0; i < 200 && start_q.size() < n0 + 2; i++) @(negedge hb_clk);
    check("t5_second_start", start_q.size() - n0, 2);
    tick(15);
    rst = 1'b1;
    tick(1);
    check("t5_tx_after_reset", int'(uart_tx), 1);
    model_reset();
    rst = 1'b0;
    ic = irq_cnt;
    ns = start_q.size();
    rd(5'd0, a, e);
    check("t5_status", a, e);
    check("t5_status_const", a, 1);
    tick(100);
    check("t5_no_irq", irq_cnt, ic);
    check("t5_no_frames", start_q.size(), ns);

    // Read path: data offset, unmapped offsets, hold with ren low
    rd_chk("t6_data_ofs_read", UART_DATA_OFS);
    rd_chk("t6_unmapped_1f", 5'h1F);
    rd(5'd4, a, e);
    check("t6_unmapped_04", a, e);
    bus.xt_hb.raddr = 32'(UART_DIV_OFS);
    tick(3);
    check("t6_rdata_hold", int'(bus.rdata), e);

    // Randomised bursts
    for (int it = 0; it < 6; it++) begin
      d  = 4 + $urandom_range(0, 3);
      nb = 1 + $urandom_range(0, 5);
      wr(UART_DIV_OFS, d);
      for (int i = 0; i < nb; i++) wr(UART_DATA_OFS, $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rd_chk("rand_status", 5'd0);
      tgt = irq_cnt + 1;
      wait_irq(tgt, 10 * 8 * nb + 50, "rand_burst_irq");
      check("rand_queue_drained", exp_q.size(), 0);
    end

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_bus.md
# uart_tx_fifo_bus

Bus-attached UART transmitter with a TX FIFO, for CPU-driven serial output of multi-byte bursts without per-byte polling. It sits on the XT high-speed bus as a slave next to the existing UART receive path. It serialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from a single bus clock, with a runtime-programmable bit period. It raises an interrupt when the FIFO has fully drained.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, range 2..8.
- `DEFAULT_DIV`, default 16'd868: bit period in `hb_clk` cycles after reset; must be ≥4.
- `DIV_W`, default 16: divisor width.
- `hb_clk` in 1: bus clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `xt_hb` in `hb_slave_t`: bus slave bundle; uses `raddr`, `waddr`, `wdata`.
- `sel` in `sel_t`: this slave's `ren` / `wen` strobes.
- `rdata` out 32: registered read data.
- `tx_irq` out 1: one-cycle pulse when transmission completes and the FIFO is empty.
- `uart_tx` out 1: serial output; idles high.

## Operation
- Register map; decode uses address bits [4:0].
  - 28, write: push `wdata[7:0]`.
  - 28, read: returns 0.
  - 24, write: divisor ← `wdata[DIV_W-1:0]`; writes with a value <4 are ignored.
  - 24, read: current divisor, zero-extended.
  - Any other offset, read: status word. Bit 0 fifo_empty, bit 1 fifo_full, bit 2 busy (FSM ≠ IDLE), bit 3 overflow, bits [11:8] fifo count; all other bits 0.
- Push while full (registered full flag) is dropped, including when a pop occurs in the same cycle. A dropped push sets sticky `overflow`.
- A status read clears `overflow`. If a status read and a dropped push coincide, set wins.
- Simultaneous push (not full) and pop: both take effect and the count is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP. Counters: baud counter `DIV_W` bits (0..div-1) and bit index 3 bits.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch the divisor into `frame_div`, → START. Otherwise hold `uart_tx`=1.
  - START: `uart_tx`=0 for `frame_div` cycles, → DATA.
  - DATA: drive `shift[0]` for `frame_div` cycles, then shift right. After bit index 7, → STOP.
  - STOP: `uart_tx`=1 for `frame_div` cycles. At the end, if FIFO non-empty, pop and → START directly (no idle gap). Otherwise → IDLE and pulse `tx_irq`.
- Divisor writes mid-frame do not affect the current frame; they apply from the next pop.

## Timing
- Reset values:
  - `uart_tx`=1, `tx_irq`=0, `rdata`=0.
  - FIFO empty, pointers 0, `overflow`=0.
  - divisor=`DEFAULT_DIV`, FSM IDLE.
- Reset mid-frame: `uart_tx` returns to 1 at the reset edge and queued bytes are discarded.
- `rdata` updates only on an edge where `sel.ren`=1, one cycle after the request; otherwise it holds.
- Push latency from an idle FIFO:
  - Write accepted at edge N; count=1 after N.
  - Pop and → START at edge N+1; `uart_tx` falls after edge N+1.
- Frame length is exactly 10·`frame_div` cycles. Back-to-back frames are contiguous.
- `tx_irq` is high for exactly the one cycle after the STOP→IDLE edge.
- `uart_tx` is driven from a flop; no combinational path from bus inputs.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum (2 bits);
  - offset constants `UART_DATA_OFS`=28 and `UART_DIV_OFS`=24;
  - packed `uart_tx_status_t`;
  - `UART_MIN_DIV`=4.
- One sub-module, `sync_fifo`: single-clock, parameterised width/depth; `push`/`pop`/`full`/`empty`/`count`; synchronous active-high reset.

## Test plan
- Reset, write 0x55 to offset 28 with div=4 → `uart_tx` low 4 cycles starting after edge N+1, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles, then `tx_irq` pulse; total 40 cycles.
- Write div=8, push 0xA3, 0x0F, 0xFF → three contiguous 80-cycle frames with no idle gap; exactly one `tx_irq`, after the third stop bit.
- Push 9 bytes into depth 8 while busy → status shows fifo_full=1, overflow=1, count=8. Next status read returns overflow=1; the following read returns overflow=0.
- Mid-frame div write 4→12 → current frame completes at 4 cycles/bit; next frame runs at 12 cycles/bit. A write of div=2 is ignored and reading offset 24 returns the prior value.
- Assert `rst` during DATA of the 2nd queued byte → `uart_tx`=1 the next cycle, status = 0x1 (empty), no `tx_irq`, no further frames.
- Read offset 28 and an unmapped offset with `ren` → `rdata` = 0 and the status word respectively, one cycle later; `rdata` holds when `ren`=0.
